// File: rtl/coin_acceptor_pkg.sv
// coin_acceptor_pkg: shared types and default thresholds for the coin-slot front-end.
package coin_acceptor_pkg;
    localparam int CNT_W     = 8;
    localparam int NOISE_MAX = 2;
    localparam int SMALL_MIN = 4;
    localparam int SMALL_MAX = 10;
    localparam int LARGE_MIN = 12;
    localparam int LARGE_MAX = 24;
    localparam int JAM_LIM   = 200;
    typedef enum logic [1:0] {COIN_NONE = 2'd0, COIN_ONE = 2'd1, COIN_TWO = 2'd2} coin_t;
    typedef enum logic [2:0] {ARM, IDLE, MEASURE, EMIT, REJECT, JAM} acc_state_t;
endpackage

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: sensor/accept inputs and classification outputs of the coin acceptor.
interface coin_acceptor_if;
    import coin_acceptor_pkg::*;
    logic  coin_sense;
    logic  accept_en;
    coin_t coin;
    logic  reject;
    logic  jam;
    logic  busy;
    modport master (output coin_sense, accept_en, input coin, reject, jam, busy);
    modport slave  (input coin_sense, accept_en, output coin, reject, jam, busy);
endinterface

// File: rtl/coin_acceptor_sense_sync.sv
// sense_sync: two-flop synchronizer for asynchronous slot sensors, sync reset to 0.
module sense_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta, r_q;
    always_ff @(posedge clk) begin
        if (rst) {r_q, r_meta} <= 2'b00;
        else     {r_q, r_meta} <= {r_meta, i_d};
    end
    assign o_q = r_q;
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: times sensor occlusion and classifies it as a small/large coin, reject or jam.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int P_CNT_W     = CNT_W,
    parameter int P_NOISE_MAX = NOISE_MAX,
    parameter int P_SMALL_MIN = SMALL_MIN,
    parameter int P_SMALL_MAX = SMALL_MAX,
    parameter int P_LARGE_MIN = LARGE_MIN,
    parameter int P_LARGE_MAX = LARGE_MAX,
    parameter int P_JAM_LIM   = JAM_LIM
) (
    input logic             clk,
    input logic             rst,
    coin_acceptor_if.slave  io_bus
);
    localparam logic [P_CNT_W-1:0] L_ONE   = P_CNT_W'(1);
    localparam logic [P_CNT_W-1:0] L_ARMED = P_CNT_W'(2);
    localparam logic [P_CNT_W-1:0] L_NOISE = P_CNT_W'(P_NOISE_MAX);
    localparam logic [P_CNT_W-1:0] L_S_MIN = P_CNT_W'(P_SMALL_MIN);
    localparam logic [P_CNT_W-1:0] L_S_MAX = P_CNT_W'(P_SMALL_MAX);
    localparam logic [P_CNT_W-1:0] L_L_MIN = P_CNT_W'(P_LARGE_MIN);
    localparam logic [P_CNT_W-1:0] L_L_MAX = P_CNT_W'(P_LARGE_MAX);
    localparam logic [P_CNT_W-1:0] L_JAM   = P_CNT_W'(P_JAM_LIM);
    logic               w_sense;
    acc_state_t         r_state, w_state;
    logic [P_CNT_W-1:0] r_cnt, w_cnt;
    coin_t              r_coin, w_code;
    logic               r_reject, r_jam, r_busy;
    sense_sync u_sync (.clk(clk), .rst(rst), .i_d(io_bus.coin_sense), .o_q(w_sense));
    // ARM reuses cnt to let the synchronizer refill before trusting sense_s=0
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_code  = COIN_NONE;
        case (r_state)
            ARM: begin
                if (r_cnt < L_ARMED) w_cnt = r_cnt + L_ONE;
                else if (!w_sense) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end
            end
            IDLE: begin
                w_state = w_sense ? MEASURE : IDLE;
                w_cnt   = w_sense ? L_ONE : r_cnt;
            end
            MEASURE: begin
                if (w_sense) begin
                    w_cnt   = (&r_cnt) ? r_cnt : r_cnt + L_ONE;
                    w_state = (w_cnt >= L_JAM) ? JAM : MEASURE;
                end else if (r_cnt <= L_NOISE) begin
                    w_state = IDLE;
                end else begin
                    w_code  = !io_bus.accept_en ? COIN_NONE :
                              (r_cnt >= L_S_MIN && r_cnt <= L_S_MAX) ? COIN_ONE :
                              (r_cnt >= L_L_MIN && r_cnt <= L_L_MAX) ? COIN_TWO : COIN_NONE;
                    w_state = (w_code != COIN_NONE) ? EMIT : REJECT;
                end
            end
            EMIT, REJECT: begin
                w_state = w_sense ? MEASURE : IDLE;
                w_cnt   = w_sense ? L_ONE : r_cnt;
            end
            JAM:     w_state = w_sense ? JAM : REJECT;
            default: w_state = ARM;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARM;
            r_cnt    <= '0;
            r_coin   <= COIN_NONE;
            r_reject <= 1'b0;
            r_jam    <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_coin   <= w_code;
            r_reject <= (w_state == REJECT);
            r_jam    <= (w_state == JAM);
            r_busy   <= (w_state != IDLE);
        end
    end
    assign io_bus.coin   = r_coin;
    assign io_bus.reject = r_reject;
    assign io_bus.jam    = r_jam;
    assign io_bus.busy   = r_busy;
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed-vector bench for coin_acceptor with immediate-assertion checks.
module tb_coin_acceptor;
    import coin_acceptor_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0, miscompares = 0;
    int n_c1 = 0, n_c2 = 0, n_rej = 0, n_both = 0;
    int b_c1, b_c2, b_rej, b_both;
    coin_acceptor_if bus();
    coin_acceptor dut (.clk(clk), .rst(rst), .io_bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.coin == COIN_ONE) n_c1++;
        if (bus.coin == COIN_TWO) n_c2++;
        if (bus.reject) n_rej++;
        if ((bus.coin != COIN_NONE && bus.reject) || bus.coin == 2'd3) n_both++;
    end
    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic snap();
        b_c1 = n_c1; b_c2 = n_c2; b_rej = n_rej; b_both = n_both;
    endtask
    task automatic hold(input int n);
        bus.coin_sense = 1'b1;
        repeat (n) @(negedge clk);
        bus.coin_sense = 1'b0;
    endtask
    task automatic observe(input string tag, input int e1, input int e2, input int er, input int elat);
        int lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (lat == 0 && (bus.coin != COIN_NONE || bus.reject)) lat = i;
        end
        #1;
        check({tag, " coin1 cycles"}, n_c1 - b_c1, e1);
        check({tag, " coin2 cycles"}, n_c2 - b_c2, e2);
        check({tag, " reject cycles"}, n_rej - b_rej, er);
        check({tag, " latency"}, lat, elat);
        check({tag, " coin+reject overlap"}, n_both - b_both, 0);
        check({tag, " busy idle"}, int'(bus.busy), 0);
    endtask
    initial begin
        bus.coin_sense = 1'b0;
        bus.accept_en  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset coin", int'(bus.coin), 0);
        check("reset reject", int'(bus.reject), 0);
        check("reset jam", int'(bus.jam), 0);
        check("reset busy", int'(bus.busy), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("armed busy", int'(bus.busy), 0);
        snap(); hold(6);  observe("small6", 1, 0, 0, 3);
        snap(); hold(15); observe("large15", 0, 1, 0, 3);
        snap(); hold(11); observe("gap11", 0, 0, 1, 3);
        snap(); hold(2);  observe("noise2", 0, 0, 0, 0);
        snap(); hold(3);  observe("short3", 0, 0, 1, 3);
        snap(); hold(4);  observe("small4", 1, 0, 0, 3);
        snap(); hold(10); observe("small10", 1, 0, 0, 3);
        snap(); hold(12); observe("large12", 0, 1, 0, 3);
        snap(); hold(24); observe("large24", 0, 1, 0, 3);
        snap(); hold(25); observe("long25", 0, 0, 1, 3);
        bus.accept_en = 1'b0;
        snap(); hold(6);  observe("disabled6", 0, 0, 1, 3);
        bus.accept_en = 1'b1;
        snap(); hold(6); @(negedge clk); hold(6);
        observe("back2back", 2, 0, 0, 3);
        snap();
        bus.coin_sense = 1'b1;
        repeat (199) @(negedge clk);
        check("jam before limit", int'(bus.jam), 0);
        repeat (4) @(negedge clk);
        check("jam at limit", int'(bus.jam), 1);
        check("jam busy", int'(bus.busy), 1);
        repeat (47) @(negedge clk);
        bus.coin_sense = 1'b0;
        observe("jam250", 0, 0, 1, 3);
        check("jam cleared", int'(bus.jam), 0);
        snap();
        bus.coin_sense = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst coin", int'(bus.coin), 0);
        check("midrst reject", int'(bus.reject), 0);
        check("midrst busy", int'(bus.busy), 1);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        bus.coin_sense = 1'b0;
        observe("midrst drop", 0, 0, 0, 0);
        snap(); hold(6); observe("after rst", 1, 0, 0, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
